// File: rtl/bldcm_pkg.sv
// Shared constants for the BLDC motor ramp controller: register maps of this block and
// the motor slave, Avalon response codes and the ramp FSM encoding.
package bldcm_pkg;

    // Motor-side (mBldcm) register addresses
    localparam logic [1:0] MOTOR_FREQ   = 2'd0;
    localparam logic [1:0] MOTOR_STATUS = 2'd3;

    // Host-side register addresses of this block
    localparam logic [1:0] REG_TARGET   = 2'd0;
    localparam logic [1:0] REG_STEP     = 2'd1;
    localparam logic [1:0] REG_INTERVAL = 2'd2;
    localparam logic [1:0] REG_CTRL     = 2'd3;

    localparam int CTRL_EN_BIT   = 0;
    localparam int CTRL_BUSY_BIT = 1;
    localparam int CTRL_ERR_BIT  = 2;

    // Avalon response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_WRITE = 3'd2,
        ST_RESP  = 3'd3,
        ST_RDBK  = 3'd4,
        ST_FAULT = 3'd5
    } state_e;

endpackage

// File: rtl/bldcm_ramp_regs.sv
// Host-facing register file: TARGET, STEP, INTERVAL and CTRL/STATUS with a sticky,
// write-one-to-clear error bit.
module bldcm_ramp_regs
    import bldcm_pkg::*;
#(
    parameter int pIntervalWidth = 24,
    parameter int pFreqWidth     = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                addr,
    input  logic                      rd,
    output logic [31:0]               rdata,
    output logic [1:0]                resp,
    input  logic                      wr,
    input  logic [31:0]               wdata,
    input  logic                      busy,
    input  logic                      set_err,
    output logic [pFreqWidth-1:0]     target,
    output logic [pFreqWidth-1:0]     step,
    output logic [pIntervalWidth-1:0] interval,
    output logic                      en,
    output logic                      err
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata    <= '0;
            resp     <= RESP_OKAY;
            target   <= '0;
            step     <= '0;
            interval <= '0;
            en       <= 1'b0;
            err      <= 1'b0;
        end else begin
            rdata <= '0;
            resp  <= RESP_OKAY;
            if (rd) begin
                case (addr)
                    REG_TARGET:   rdata <= 32'(target);
                    REG_STEP:     rdata <= 32'(step);
                    REG_INTERVAL: rdata <= 32'(interval);
                    default:      rdata <= {29'd0, err, busy, en};
                endcase
            end
            if (wr) begin
                case (addr)
                    REG_TARGET:   target   <= wdata[pFreqWidth-1:0];
                    REG_STEP:     step     <= wdata[pFreqWidth-1:0];
                    REG_INTERVAL: interval <= wdata[pIntervalWidth-1:0];
                    default: begin
                        en <= wdata[CTRL_EN_BIT];
                        if (wdata[CTRL_ERR_BIT]) err <= 1'b0;
                    end
                endcase
            end
            // A fault reported in the same cycle as a host clear must not be lost
            if (set_err) err <= 1'b1;
        end
    end

endmodule

// File: rtl/bldcm_ramp_ctrl.sv
// Ramps the mBldcm motor frequency towards TARGET in STEP increments, one master write per
// INTERVAL. Optional read-back verification is enabled with `define BLDCM_RAMP_READBACK_EN.
module bldcm_ramp_ctrl
    import bldcm_pkg::*;
#(
    parameter int pIntervalWidth = 24,
    parameter int pFreqWidth     = 32
) (
    input  logic        iClock,
    input  logic        iReset_n,
    // Both Avalon ports: a strobe (iRead/iWrite, oMRead/oMWrite) is a one-cycle request with
    // no waitrequest; the response (data + resp code) is valid exactly one cycle later.
    input  logic [1:0]  iAddr,
    input  logic        iRead,
    output logic [31:0] oRdata,
    input  logic        iWrite,
    input  logic [31:0] iWdata,
    output logic [1:0]  oResp,
    output logic [1:0]  oMAddr,
    output logic        oMRead,
    input  logic [31:0] iMRdata,
    output logic        oMWrite,
    output logic [31:0] oMWdata,
    input  logic [1:0]  iMResp,
    output logic        oBusy,
    output logic        oError,
    output state_e      dbg_state
);

    logic [pFreqWidth-1:0]     target, step, cur, nxt_val, calc, diff;
    logic [pIntervalWidth-1:0] interval, cnt;
    logic                      en, err, set_err, load_cnt, up;
    state_e                    state, state_nxt;

    bldcm_ramp_regs #(
        .pIntervalWidth (pIntervalWidth),
        .pFreqWidth     (pFreqWidth)
    ) u_regs (
        .clk      (iClock),
        .rst_n    (iReset_n),
        .addr     (iAddr),
        .rd       (iRead),
        .rdata    (oRdata),
        .resp     (oResp),
        .wr       (iWrite),
        .wdata    (iWdata),
        .busy     (oBusy),
        .set_err  (set_err),
        .target   (target),
        .step     (step),
        .interval (interval),
        .en       (en),
        .err      (err)
    );

    // Clamp to TARGET whenever one more step would reach or pass it, so no wrap can occur
    always_comb begin
        up   = target > cur;
        diff = up ? (target - cur) : (cur - target);
        if (step == '0 || diff <= step) calc = target;
        else if (up)                    calc = cur + step;
        else                            calc = cur - step;
    end

`ifdef BLDCM_RAMP_READBACK_EN
    logic rb_phase;
    always_ff @(posedge iClock) begin
        if (!iReset_n) rb_phase <= 1'b0;
        else           rb_phase <= (state == ST_RDBK) && !rb_phase;
    end
`else
    logic rdbk_unused;
    assign rdbk_unused = ^iMRdata;
`endif

    always_comb begin
        state_nxt = state;
        set_err   = 1'b0;
        load_cnt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en && cur != target) begin
                    state_nxt = ST_WAIT;
                    load_cnt  = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!en || cur == target) state_nxt = ST_IDLE;
                else if (cnt == '0)       state_nxt = ST_WRITE;
            end
            ST_WRITE: state_nxt = ST_RESP;
            ST_RESP: begin
                if (iMResp != RESP_OKAY) begin
                    set_err   = 1'b1;
                    state_nxt = ST_FAULT;
                end else begin
`ifdef BLDCM_RAMP_READBACK_EN
                    state_nxt = ST_RDBK;
`else
                    // CUR only takes nxt_val at this edge, so decide on the new value
                    if (en && nxt_val != target) begin
                        state_nxt = ST_WAIT;
                        load_cnt  = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
`endif
                end
            end
`ifdef BLDCM_RAMP_READBACK_EN
            ST_RDBK: begin
                if (rb_phase) begin
                    if (iMResp != RESP_OKAY || iMRdata[pFreqWidth-1:0] != cur) begin
                        set_err   = 1'b1;
                        state_nxt = ST_FAULT;
                    end else if (en && cur != target) begin
                        state_nxt = ST_WAIT;
                        load_cnt  = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
`endif
            ST_FAULT: if (!err) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (!iReset_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cur     <= '0;
            nxt_val <= '0;
        end else begin
            state <= state_nxt;
            if (load_cnt)                          cnt <= interval;
            else if (state == ST_WAIT && cnt != '0) cnt <= cnt - pIntervalWidth'(1);
            if (state == ST_WRITE) nxt_val <= calc;
            if (state == ST_RESP && iMResp == RESP_OKAY) cur <= nxt_val;
        end
    end

    // Strobes are gated by reset so an asserted reset cuts a transaction in the same cycle
    always_comb begin
        oBusy   = iReset_n && (state == ST_WAIT || state == ST_WRITE ||
                               state == ST_RESP || state == ST_RDBK);
        oMWrite = iReset_n && (state == ST_WRITE);
        oMWdata = oMWrite ? 32'(calc) : 32'd0;
        oMAddr  = MOTOR_FREQ;
`ifdef BLDCM_RAMP_READBACK_EN
        oMRead  = iReset_n && (state == ST_RDBK) && !rb_phase;
`else
        oMRead  = 1'b0;
`endif
    end

    assign oError    = err;
    assign dbg_state = state;

endmodule

// File: tb/tb_bldcm_ramp_ctrl.sv
// Directed bench for bldcm_ramp_ctrl: register table, ramp up/down, fault/recover,
// EN clear mid-ramp, reset mid-transaction and (when enabled) read-back failure.
module tb_bldcm_ramp_ctrl;
    import bldcm_pkg::*;

    logic        iClock = 1'b0;
    logic        iReset_n = 1'b0;
    logic [1:0]  iAddr = '0;
    logic        iRead = 1'b0;
    logic [31:0] oRdata;
    logic        iWrite = 1'b0;
    logic [31:0] iWdata = '0;
    logic [1:0]  oResp;
    logic [1:0]  oMAddr;
    logic        oMRead;
    logic [31:0] iMRdata = '0;
    logic        oMWrite;
    logic [31:0] oMWdata;
    logic [1:0]  iMResp = 2'b00;
    logic        oBusy;
    logic        oError;
    state_e      dbg_state;

    bldcm_ramp_ctrl dut (
        .iClock    (iClock),
        .iReset_n  (iReset_n),
        .iAddr     (iAddr),
        .iRead     (iRead),
        .oRdata    (oRdata),
        .iWrite    (iWrite),
        .iWdata    (iWdata),
        .oResp     (oResp),
        .oMAddr    (oMAddr),
        .oMRead    (oMRead),
        .iMRdata   (iMRdata),
        .oMWrite   (oMWrite),
        .oMWdata   (oMWdata),
        .iMResp    (iMResp),
        .oBusy     (oBusy),
        .oError    (oError),
        .dbg_state (dbg_state)
    );

    // Clock
    initial forever #5 iClock = ~iClock;

    // Scoreboard state
    logic [31:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_wr_cyc = -1;
    int min_gap = 1000;
    int fault_idx = -1;
    int wr_count = 0;
    int strobe_viol = 0;
    bit rd_zero = 1'b0;
    bit saw_read = 1'b0;
    bit prev_strobe = 1'b0;
    logic [31:0] last_wdata = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Motor model and write monitor, evaluated mid-cycle
    always @(negedge iClock) begin
        if (oMWrite) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_mwrite: got write of %0d, expected no write", oMWdata);
            end else begin
                check("mwrite_data", oMWdata, exp_q.pop_front());
                check("mwrite_addr", 32'(oMAddr), 32'(MOTOR_FREQ));
            end
            if (last_wr_cyc >= 0 && cyc - last_wr_cyc < min_gap) min_gap = cyc - last_wr_cyc;
            last_wr_cyc = cyc;
            iMResp = (wr_count == fault_idx) ? RESP_SLVERR : RESP_OKAY;
            wr_count++;
            last_wdata = oMWdata;
        end
        if (oMRead) begin
            saw_read = 1'b1;
            iMResp = RESP_OKAY;
            iMRdata = rd_zero ? 32'd0 : last_wdata;
        end
        if ((oMRead && oMWrite) || ((oMRead || oMWrite) && prev_strobe)) strobe_viol++;
        prev_strobe = oMRead || oMWrite;
        cyc++;
    end

    // Driver tasks
    task automatic host_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge iClock);
        iAddr = a;
        iWdata = d;
        iWrite = 1'b1;
        @(negedge iClock);
        iWrite = 1'b0;
    endtask

    task automatic host_read(input logic [1:0] a, output logic [31:0] d, output logic [1:0] r);
        @(negedge iClock);
        iAddr = a;
        iRead = 1'b1;
        @(negedge iClock);
        d = oRdata;
        r = oResp;
        iRead = 1'b0;
    endtask

    task automatic read_check(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic [1:0] r;
        host_read(a, d, r);
        check(name, d, exp);
        check({name, "_resp"}, 32'(r), 32'(RESP_OKAY));
    endtask

    task automatic do_reset();
        @(negedge iClock);
        iReset_n = 1'b0;
        repeat (3) @(negedge iClock);
        iReset_n = 1'b1;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || oBusy) && n < budget) begin
            @(negedge iClock);
            n++;
        end
        check(name, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_mwrite(input string name, input int budget);
        int n = 0;
        do begin
            @(negedge iClock);
            n++;
        end while (!oMWrite && n < budget);
        check(name, 32'(n < budget), 32'd1);
    endtask

    typedef struct {
        bit          is_wr;
        logic [1:0]  addr;
        logic [31:0] data;   // write data, or expected read data
    } vec_t;

    vec_t vecs[17];

    initial begin
        vecs[0]  = '{1'b0, REG_TARGET,   32'h0000_0000};
        vecs[1]  = '{1'b0, REG_STEP,     32'h0000_0000};
        vecs[2]  = '{1'b0, REG_INTERVAL, 32'h0000_0000};
        vecs[3]  = '{1'b0, REG_CTRL,     32'h0000_0000};
        vecs[4]  = '{1'b1, REG_TARGET,   32'h1234_5678};
        vecs[5]  = '{1'b0, REG_TARGET,   32'h1234_5678};
        vecs[6]  = '{1'b1, REG_STEP,     32'hA5A5_A5A5};
        vecs[7]  = '{1'b0, REG_STEP,     32'hA5A5_A5A5};
        vecs[8]  = '{1'b1, REG_INTERVAL, 32'hFFFF_FFFF};
        vecs[9]  = '{1'b0, REG_INTERVAL, 32'h00FF_FFFF};
        vecs[10] = '{1'b1, REG_CTRL,     32'hFFFF_FFFA};
        vecs[11] = '{1'b0, REG_CTRL,     32'h0000_0000};
        vecs[12] = '{1'b1, REG_TARGET,   32'h0000_0000};
        vecs[13] = '{1'b1, REG_STEP,     32'h0000_0000};
        vecs[14] = '{1'b1, REG_INTERVAL, 32'h0000_0000};
        vecs[15] = '{1'b0, REG_TARGET,   32'h0000_0000};
        vecs[16] = '{1'b0, REG_INTERVAL, 32'h0000_0000};

        // Reset state
        repeat (3) @(negedge iClock);
        check("rst_mwrite", 32'(oMWrite), 32'd0);
        check("rst_mread", 32'(oMRead), 32'd0);
        check("rst_mwdata", oMWdata, 32'd0);
        check("rst_maddr", 32'(oMAddr), 32'd0);
        check("rst_busy", 32'(oBusy), 32'd0);
        check("rst_error", 32'(oError), 32'd0);
        check("rst_rdata", oRdata, 32'd0);
        check("rst_resp", 32'(oResp), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        iReset_n = 1'b1;

        // Register table
        for (int i = 0; i < 17; i++) begin
            if (vecs[i].is_wr) host_write(vecs[i].addr, vecs[i].data);
            else read_check($sformatf("reg_vec%0d", i), vecs[i].addr, vecs[i].data);
        end

        // Ramp up 0 -> 1000 by 300 with INTERVAL=4
        host_write(REG_STEP, 32'd300);
        host_write(REG_INTERVAL, 32'd4);
        exp_q.push_back(32'd300);
        exp_q.push_back(32'd600);
        exp_q.push_back(32'd900);
        exp_q.push_back(32'd1000);
        host_write(REG_TARGET, 32'd1000);
        min_gap = 1000;
        last_wr_cyc = -1;
        host_write(REG_CTRL, 32'd1);
        wait_done("ramp_up_done", 300);
        check("ramp_up_gap_ge5", 32'(min_gap >= 5), 32'd1);
        read_check("ramp_up_status", REG_CTRL, 32'd1);

        // Ramp down 1000 -> 100
        exp_q.push_back(32'd700);
        exp_q.push_back(32'd400);
        exp_q.push_back(32'd100);
        host_write(REG_TARGET, 32'd100);
        wait_done("ramp_down_done", 300);
        check("ramp_down_busy", 32'(oBusy), 32'd0);

        // STEP=0 jumps straight to TARGET
        host_write(REG_STEP, 32'd0);
        exp_q.push_back(32'd2083333);
        host_write(REG_TARGET, 32'd2083333);
        wait_done("step0_done", 100);
        check("step0_state", 32'(dbg_state), 32'(ST_IDLE));

        // Reset during a master write: strobe drops at once, nothing follows
        do_reset();
        host_write(REG_STEP, 32'd300);
        exp_q.push_back(32'd300);
        host_write(REG_TARGET, 32'd1000);
        host_write(REG_CTRL, 32'd1);
        wait_mwrite("rstmid_write_seen", 50);
        #2;
        iReset_n = 1'b0;
        #1;
        check("rstmid_mwrite_low", 32'(oMWrite), 32'd0);
        check("rstmid_mwdata_zero", oMWdata, 32'd0);
        repeat (3) @(negedge iClock);
        check("rstmid_state", 32'(dbg_state), 32'(ST_IDLE));
        iReset_n = 1'b1;
        repeat (10) @(negedge iClock);
        check("rstmid_q_empty", 32'(exp_q.size()), 32'd0);
        read_check("rstmid_target", REG_TARGET, 32'd0);

        // SLVERR on the second write -> FAULT, then w1c recovers from CUR=300
        host_write(REG_STEP, 32'd300);
        host_write(REG_INTERVAL, 32'd4);
        wr_count = 0;
        fault_idx = 1;
        exp_q.push_back(32'd300);
        exp_q.push_back(32'd600);
        host_write(REG_TARGET, 32'd1000);
        host_write(REG_CTRL, 32'd1);
        wait_done("fault_writes", 300);
        repeat (3) @(negedge iClock);
        check("fault_error", 32'(oError), 32'd1);
        check("fault_state", 32'(dbg_state), 32'(ST_FAULT));
        check("fault_busy", 32'(oBusy), 32'd0);
        read_check("fault_status", REG_CTRL, 32'd5);
        repeat (20) @(negedge iClock);
        fault_idx = -1;
        exp_q.push_back(32'd600);
        exp_q.push_back(32'd900);
        exp_q.push_back(32'd1000);
        host_write(REG_CTRL, 32'd5);
        check("fault_cleared", 32'(oError), 32'd0);
        wait_done("fault_resume_done", 300);

        // Clear EN while the first write is in RESP
        do_reset();
        host_write(REG_STEP, 32'd300);
        host_write(REG_INTERVAL, 32'd4);
        exp_q.push_back(32'd300);
        host_write(REG_TARGET, 32'd1000);
        host_write(REG_CTRL, 32'd1);
        wait_mwrite("enclr_write_seen", 50);
        host_write(REG_CTRL, 32'd0);
        repeat (20) @(negedge iClock);
        check("enclr_q_empty", 32'(exp_q.size()), 32'd0);
        read_check("enclr_status", REG_CTRL, 32'd0);
        exp_q.push_back(32'd600);
        exp_q.push_back(32'd900);
        exp_q.push_back(32'd1000);
        host_write(REG_CTRL, 32'd1);
        wait_done("enclr_resume_done", 300);

`ifdef BLDCM_RAMP_READBACK_EN
        // Motor reads back 0 after a write of 300
        do_reset();
        rd_zero = 1'b1;
        host_write(REG_STEP, 32'd300);
        host_write(REG_INTERVAL, 32'd4);
        exp_q.push_back(32'd300);
        host_write(REG_TARGET, 32'd1000);
        host_write(REG_CTRL, 32'd1);
        wait_mwrite("rdbk_write_seen", 50);
        repeat (6) @(negedge iClock);
        check("rdbk_read_seen", 32'(saw_read), 32'd1);
        check("rdbk_error", 32'(oError), 32'd1);
        check("rdbk_state", 32'(dbg_state), 32'(ST_FAULT));
        repeat (20) @(negedge iClock);
        check("rdbk_q_empty", 32'(exp_q.size()), 32'd0);
`else
        check("no_mread", 32'(saw_read), 32'd0);
`endif

        check("strobe_rules", 32'(strobe_viol), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bldcm_ramp_ctrl.md
BLDCM_RAMP_CTRL -- requirements
Module: bldcm_ramp_ctrl

Interface
REQ-001 SHALL have parameter pIntervalWidth, default 24, width of the step-interval counter in clock cycles.
REQ-002 SHALL have parameter pFreqWidth, default 32, width of frequency values.
REQ-003 SHALL have iClock  input  1  single clock for all logic.
REQ-004 SHALL have iReset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have host Avalon-MM slave ports iAddr in 2, iRead in 1, oRdata out 32, iWrite in 1, iWdata in 32, oResp out 2.
REQ-006 SHALL have motor-side Avalon-MM master ports oMAddr out 2, oMRead out 1, iMRdata in 32, oMWrite out 1, oMWdata out 32, iMResp in 2, for driving the mBldcm slave.
REQ-007 SHALL have oBusy  out  1  ramp in progress, and oError  out  1  sticky fault.

Function
REQ-008 SHALL implement slave registers: addr 0 TARGET, addr 1 STEP, addr 2 INTERVAL (low pIntervalWidth bits), addr 3 CTRL/STATUS (bit0 EN rw, bit1 BUSY ro, bit2 ERR w1c, bits[31:3] read 0).
REQ-009 SHALL return slave read data and oResp on the cycle after iRead, with oResp 2'b00; writes take effect on the cycle after iWrite.
REQ-010 SHALL run FSM states IDLE, WAIT, WRITE, RESP, RDBK, FAULT.
REQ-011 IDLE->WAIT when EN=1 and CUR!=TARGET; WAIT loads counter with INTERVAL and moves to WRITE when it reaches 0 (INTERVAL=0 gives a 1-cycle WAIT).
REQ-012 WRITE SHALL assert oMWrite for exactly one cycle with oMAddr=0 and oMWdata=NEXT, then enter RESP.
REQ-013 NEXT = TARGET if |TARGET-CUR| <= STEP or STEP=0; otherwise CUR+STEP when ramping up, CUR-STEP when ramping down. Arithmetic is unsigned pFreqWidth with no wrap-around.
REQ-014 RESP SHALL sample iMResp one cycle after oMWrite: 2'b00 sets CUR=NEXT and goes to RDBK if enabled, else to WAIT if CUR!=TARGET, else IDLE; any other value sets ERR and goes to FAULT.
REQ-015 FAULT SHALL hold all master strobes low until ERR is cleared via w1c, then go to IDLE.
REQ-016 A TARGET or STEP write mid-ramp SHALL be used at the next NEXT computation; an in-flight transaction is never aborted.
REQ-017 Clearing EN mid-ramp SHALL complete any in-flight transaction, then go to IDLE with CUR held.
REQ-018 oBusy SHALL be 1 in WAIT, WRITE, RESP and RDBK, and 0 otherwise.
REQ-019 Master oMRead and oMWrite SHALL never both be asserted, and SHALL never be asserted on consecutive cycles.

Reset
REQ-020 Under reset: CUR, TARGET, STEP, INTERVAL and CTRL = 0; FSM = IDLE; oRdata = 0; oResp = 2'b00; all master outputs = 0; oBusy = 0; oError = 0.
REQ-021 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no further strobes.

Configuration
REQ-022 Macro BLDCM_RAMP_READBACK_EN defined: after RESP succeeds, RDBK issues a one-cycle oMRead to addr 0 and compares iMRdata on the next cycle against CUR; mismatch or iMResp!=00 sets ERR and goes to FAULT.
REQ-023 Macro undefined: the RDBK state and its logic are absent, and oMRead is tied to 0.

Structure
REQ-024 A shared package bldcm_pkg SHALL hold the register address constants (FREQ=0, STATUS=3 for the motor; TARGET/STEP/INTERVAL/CTRL for this block), the Avalon response codes (OKAY=00, SLVERR=10) and the FSM state encoding.
REQ-025 Sub-module bldcm_ramp_regs SHALL contain the host slave register file; the FSM and master interface stay at top level.

Verification
REQ-026 TARGET=1000, STEP=300, INTERVAL=4, EN=1, motor responds 00 -> master writes 300, 600, 900, 1000, with at least 5 cycles between writes; then oBusy=0 and CUR=1000.
REQ-027 Continuing from CUR=1000, write TARGET=100 -> writes 700, 400, 100 (ramp down, no underflow).
REQ-028 STEP=0, TARGET=2083333 -> a single write of 2083333.
REQ-029 Motor returns iMResp=2'b10 on the second write -> oError=1, FSM in FAULT, no further strobes; write 1 to CTRL bit2 -> oError=0, ramp resumes from CUR=300.
REQ-030 Clear EN during RESP -> that write completes and CUR updates, then no further writes; host read of addr 3 shows BUSY=0.
REQ-031 With BLDCM_RAMP_READBACK_EN defined, the motor returns read data 0 for a write of 300 -> oError=1; with the macro undefined, oMRead stays 0 throughout.
